// File: rtl/armleobus_burst_sram.sv
// -----------------------------------------------------------------------------
// armleobus_burst_sram
//
// Single-port burst SRAM slave for ArmleoBus. A request (transaction=1) is
// captured in IDLE together with cmd, address and burstcount. Each beat then
// takes WAIT_CYCLES idle cycles followed by a one-cycle transaction_done pulse.
// Every beat carries its own response; error beats neither abort the burst nor
// write memory.
//
// Parameters
//   ADDR_WIDTH   word-address bits, memory depth 2**ADDR_WIDTH x 32 bit
//   WAIT_CYCLES  idle cycles before each beat's done (0..15)
//   ERR_BASE     first word index of the error-injection window
//   ERR_LIMIT    last word index (inclusive) of the error-injection window
//
// Build option
//   ARMLEOBUS_BURST_SRAM_ERR_INJECT_EN  when defined, beats whose word index
//                                       falls in [ERR_BASE, ERR_LIMIT] answer
//                                       UNKNOWN_ADDRESS and do not write
//
// Ports
//   clk                   clock, all state on the rising edge
//   rst_n                 asynchronous active-low reset
//   transaction           request valid
//   cmd[2:0]              READ or WRITE, anything else is illegal
//   address[33:0]         byte address of the first beat
//   burstcount[3:0]       beats minus one
//   wdata[31:0]           write data of the current beat
//   wbyte_enable[3:0]     per-byte write enable
//   transaction_done      one-cycle pulse per completed beat
//   transaction_response  beat status, valid with transaction_done
//   rdata[31:0]           read data, valid with transaction_done on reads
// -----------------------------------------------------------------------------
module armleobus_burst_sram #(
   parameter int          ADDR_WIDTH  = 10,
   parameter int          WAIT_CYCLES = 1,
   parameter int unsigned ERR_BASE    = 0,
   parameter int unsigned ERR_LIMIT   = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        transaction,
   input  logic [2:0]  cmd,
   input  logic [33:0] address,
   input  logic [3:0]  burstcount,
   input  logic [31:0] wdata,
   input  logic [3:0]  wbyte_enable,
   output logic        transaction_done,
   output logic [2:0]  transaction_response,
   output logic [31:0] rdata
);

   localparam logic [2:0] ARMLEOBUS_CMD_READ         = 3'd1;
   localparam logic [2:0] ARMLEOBUS_CMD_WRITE        = 3'd2;
   localparam logic [2:0] ARMLEOBUS_RESPONSE_SUCCESS = 3'd0;
   localparam logic [2:0] ARMLEOBUS_UNKNOWN_ADDRESS  = 3'd3;

   localparam int       DEPTH     = 1 << ADDR_WIDTH;
   localparam bit       NO_WAIT   = (WAIT_CYCLES == 0);
   // wait_cnt counts down to zero; the beat executes on the edge seen at zero
   localparam logic [3:0] WAIT_LOAD = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t      state;
   logic [3:0]  wait_cnt;
   logic [3:0]  beat_cnt;   // index of the next beat to execute
   logic [3:0]  burst_q;
   logic [2:0]  cmd_q;
   logic [1:0]  lo_q;       // address[1:0] of the burst, constant across beats
   logic [31:0] index_q;    // word index of the next beat to execute
   logic        last_q;     // the done currently shown is the final beat

   logic [31:0] mem [DEPTH];

   // Beat currently being executed. With WAIT_CYCLES=0 the first beat runs on
   // the capture edge itself, so it has to use the live request inputs.
   logic                  capture;
   logic                  beat_now;
   logic [2:0]            eff_cmd;
   logic [31:0]           eff_index;
   logic [1:0]            eff_lo;
   logic [3:0]            eff_burst;
   logic [3:0]            eff_beat;
   logic [33:0]           beat_addr;
   logic                  range_err;
   logic                  cmd_err;
   logic                  inject_err;
   logic                  beat_err;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] word;

   always_comb begin
      capture   = transaction && ((state == S_IDLE) || ((state == S_DONE) && last_q));
      beat_now  = ((state == S_WAIT) && (wait_cnt == 4'd0)) ||
                  (NO_WAIT && (capture || ((state == S_DONE) && !last_q)));

      eff_cmd   = capture ? cmd            : cmd_q;
      eff_index = capture ? address[33:2]  : index_q;
      eff_lo    = capture ? address[1:0]   : lo_q;
      eff_burst = capture ? burstcount     : burst_q;
      eff_beat  = capture ? 4'd0           : beat_cnt;

      // Beat byte address: index wraps in 32 bits, low bits stay those of the request
      beat_addr = {eff_index, eff_lo};
      range_err = (beat_addr >> (ADDR_WIDTH + 2)) != 34'd0;
      cmd_err   = (eff_cmd != ARMLEOBUS_CMD_READ) && (eff_cmd != ARMLEOBUS_CMD_WRITE);
`ifdef ARMLEOBUS_BURST_SRAM_ERR_INJECT_EN
      // Unsigned offset compare covers base <= index <= limit in one comparator
      inject_err = (eff_index - ERR_BASE) <= (ERR_LIMIT - ERR_BASE);
`else
      inject_err = 1'b0;
`endif
      beat_err  = (eff_lo != 2'd0) || range_err || cmd_err || inject_err;

      word      = eff_index[ADDR_WIDTH-1:0];
      // rst_n gating keeps a beat aborted by reset from writing
      mem_we    = rst_n && beat_now && !beat_err && (eff_cmd == ARMLEOBUS_CMD_WRITE);
   end

   // Memory array: no reset, contents survive rst_n
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (wbyte_enable[i]) begin
               mem[word][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

   // Control FSM and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state                <= S_IDLE;
         wait_cnt             <= 4'd0;
         beat_cnt             <= 4'd0;
         burst_q              <= 4'd0;
         cmd_q                <= 3'd0;
         lo_q                 <= 2'd0;
         index_q              <= 32'd0;
         last_q               <= 1'b0;
         transaction_done     <= 1'b0;
         transaction_response <= ARMLEOBUS_RESPONSE_SUCCESS;
         rdata                <= 32'd0;
      end else begin
         transaction_done <= 1'b0;

         if (capture) begin
            cmd_q   <= cmd;
            lo_q    <= address[1:0];
            burst_q <= burstcount;
         end

         if (beat_now) begin
            state                <= S_DONE;
            transaction_done     <= 1'b1;
            transaction_response <= beat_err ? ARMLEOBUS_UNKNOWN_ADDRESS
                                             : ARMLEOBUS_RESPONSE_SUCCESS;
            if (!beat_err && (eff_cmd == ARMLEOBUS_CMD_READ)) begin
               rdata <= mem[word];
            end
            index_q  <= eff_index + 32'd1;
            beat_cnt <= eff_beat + 4'd1;
            last_q   <= (eff_beat == eff_burst);
         end else if (capture) begin
            state    <= S_WAIT;
            wait_cnt <= WAIT_LOAD;
            index_q  <= address[33:2];
            beat_cnt <= 4'd0;
         end else begin
            case (state)
               S_WAIT: begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
               S_DONE: begin
                  if (last_q) begin
                     state <= S_IDLE;
                  end else begin
                     state    <= S_WAIT;
                     wait_cnt <= WAIT_LOAD;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_armleobus_burst_sram.sv
module tb_armleobus_burst_sram;

   localparam logic [2:0] CMD_READ  = 3'd1;
   localparam logic [2:0] CMD_WRITE = 3'd2;
   localparam logic [2:0] RESP_OK   = 3'd0;
   localparam logic [2:0] RESP_UA   = 3'd3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Instance A: WAIT_CYCLES = 1
   logic        a_trans;
   logic [2:0]  a_cmd;
   logic [33:0] a_addr;
   logic [3:0]  a_bc;
   logic [31:0] a_wdata;
   logic [3:0]  a_be;
   logic        a_done;
   logic [2:0]  a_resp;
   logic [31:0] a_rdata;

   // Instance B: WAIT_CYCLES = 0
   logic        b_trans;
   logic [2:0]  b_cmd;
   logic [33:0] b_addr;
   logic [3:0]  b_bc;
   logic [31:0] b_wdata;
   logic [3:0]  b_be;
   logic        b_done;
   logic [2:0]  b_resp;
   logic [31:0] b_rdata;

   armleobus_burst_sram #(.ADDR_WIDTH(10), .WAIT_CYCLES(1)) u_a (
      .clk(clk), .rst_n(rst_n), .transaction(a_trans), .cmd(a_cmd),
      .address(a_addr), .burstcount(a_bc), .wdata(a_wdata), .wbyte_enable(a_be),
      .transaction_done(a_done), .transaction_response(a_resp), .rdata(a_rdata));

   armleobus_burst_sram #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_b (
      .clk(clk), .rst_n(rst_n), .transaction(b_trans), .cmd(b_cmd),
      .address(b_addr), .burstcount(b_bc), .wdata(b_wdata), .wbyte_enable(b_be),
      .transaction_done(b_done), .transaction_response(b_resp), .rdata(b_rdata));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Number of rising edges until a_done is seen (-1 if it never comes)
   task automatic a_wait_done(output int k);
      k = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (a_done) begin
            k = i;
            break;
         end
      end
   endtask

   // Single beat on A; lat = edges from capture to the edge that samples done
   task automatic a_single(input logic [2:0] c, input logic [33:0] ad, input logic [31:0] wd,
                           input logic [3:0] be, output logic [2:0] resp,
                           output logic [31:0] rd, output int lat);
      int k;
      @(negedge clk);
      a_trans = 1'b1; a_cmd = c; a_addr = ad; a_bc = 4'd0; a_wdata = wd; a_be = be;
      @(posedge clk);
      #1;
      a_trans = 1'b0;
      a_wait_done(k);
      lat  = (k < 0) ? -1 : k + 1;
      resp = a_resp;
      rd   = a_rdata;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [2:0]  r;
      logic [31:0] d;
      int          lat;
      int          k;
      logic [31:0] exp_rd [4];

      a_trans = 0; a_cmd = 0; a_addr = 0; a_bc = 0; a_wdata = 0; a_be = 0;
      b_trans = 0; b_cmd = 0; b_addr = 0; b_bc = 0; b_wdata = 0; b_be = 0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_done",  {31'd0, a_done}, 32'd0);
      check("rst_resp",  {29'd0, a_resp}, {29'd0, RESP_OK});
      check("rst_rdata", a_rdata, 32'd0);
      check("rst_b_done", {31'd0, b_done}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single write then read, latency 2
      a_single(CMD_WRITE, 34'h44, 32'h1, 4'hF, r, d, lat);
      check("wr1_resp", {29'd0, r}, {29'd0, RESP_OK});
      check("wr1_lat",  32'(lat), 32'd2);
      a_single(CMD_READ, 34'h44, 32'h0, 4'h0, r, d, lat);
      check("rd1_resp",  {29'd0, r}, {29'd0, RESP_OK});
      check("rd1_lat",   32'(lat), 32'd2);
      check("rd1_rdata", d, 32'h1);

      // Byte enables
      a_single(CMD_WRITE, 34'h80, 32'hAABBCCDD, 4'hF, r, d, lat);
      a_single(CMD_WRITE, 34'h80, 32'h11223344, 4'b0101, r, d, lat);
      check("be_wr_resp", {29'd0, r}, {29'd0, RESP_OK});
      a_single(CMD_READ, 34'h80, 32'h0, 4'h0, r, d, lat);
      check("be_rdata", d, 32'hAA22CC44);

      // Misaligned and out-of-range addresses, illegal cmd
      a_single(CMD_READ, 34'h82, 32'h0, 4'h0, r, d, lat);
      check("mis_rd_resp", {29'd0, r}, {29'd0, RESP_UA});
      a_single(CMD_WRITE, 34'h82, 32'hDEADBEEF, 4'hF, r, d, lat);
      check("mis_wr_resp", {29'd0, r}, {29'd0, RESP_UA});
      a_single(CMD_READ, 34'h80, 32'h0, 4'h0, r, d, lat);
      check("mis_unchanged", d, 32'hAA22CC44);
      a_single(CMD_WRITE, 34'h0, 32'h12345678, 4'hF, r, d, lat);
      a_single(CMD_READ, 34'h1000, 32'h0, 4'h0, r, d, lat);
      check("oor_rd_resp", {29'd0, r}, {29'd0, RESP_UA});
      a_single(CMD_WRITE, 34'h1000, 32'hFFFFFFFF, 4'hF, r, d, lat);
      check("oor_wr_resp", {29'd0, r}, {29'd0, RESP_UA});
      a_single(CMD_READ, 34'h0, 32'h0, 4'h0, r, d, lat);
      check("oor_unchanged", d, 32'h12345678);
      a_single(3'd7, 34'h44, 32'h0, 4'hF, r, d, lat);
      check("badcmd_resp", {29'd0, r}, {29'd0, RESP_UA});
      a_single(CMD_READ, 34'h44, 32'h0, 4'h0, r, d, lat);
      check("badcmd_unchanged", d, 32'h1);

      // Reset in the WAIT of beat 3 of a 4-beat write
      a_single(CMD_WRITE, 34'h208, 32'hCAFE0002, 4'hF, r, d, lat);
      a_single(CMD_WRITE, 34'h20C, 32'hCAFE0003, 4'hF, r, d, lat);
      a_single(CMD_READ,  34'h0,   32'h0,        4'h0, r, d, lat);
      @(negedge clk);
      a_trans = 1'b1; a_cmd = CMD_WRITE; a_addr = 34'h200; a_bc = 4'd3;
      a_wdata = 32'hB0; a_be = 4'hF;
      @(posedge clk);
      #1;
      a_trans = 1'b0;
      a_wait_done(k);
      check("rb_beat1_gap", 32'(k), 32'd1);
      a_wdata = 32'hB1;
      a_wait_done(k);
      check("rb_beat2_gap", 32'(k), 32'd2);
      a_wdata = 32'hB2;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("rb_done",  {31'd0, a_done}, 32'd0);
      check("rb_resp",  {29'd0, a_resp}, {29'd0, RESP_OK});
      check("rb_rdata", a_rdata, 32'd0);
      #1;
      rst_n = 1'b1;
      a_single(CMD_READ, 34'h204, 32'h0, 4'h0, r, d, lat);
      check("post_rst_resp",  {29'd0, r}, {29'd0, RESP_OK});
      check("post_rst_lat",   32'(lat), 32'd2);
      check("post_rst_rdata", d, 32'hB1);

      // 4-beat read burst on A: beats spaced WAIT_CYCLES+1 apart
      exp_rd[0] = 32'hB0; exp_rd[1] = 32'hB1; exp_rd[2] = 32'hCAFE0002; exp_rd[3] = 32'hCAFE0003;
      @(negedge clk);
      a_trans = 1'b1; a_cmd = CMD_READ; a_addr = 34'h200; a_bc = 4'd3;
      @(posedge clk);
      #1;
      a_trans = 1'b0;
      for (int i = 0; i < 4; i++) begin
         a_wait_done(k);
         check($sformatf("rbst_gap%0d", i), 32'(k), (i == 0) ? 32'd1 : 32'd2);
         check($sformatf("rbst_rdata%0d", i), a_rdata, exp_rd[i]);
      end
      @(posedge clk);
      #1;
      check("rbst_done_low", {31'd0, a_done}, 32'd0);

      // B: 8-beat write burst with no wait cycles
      @(negedge clk);
      b_trans = 1'b1; b_cmd = CMD_WRITE; b_addr = 34'h100; b_bc = 4'd7;
      b_wdata = 32'd0; b_be = 4'hF;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         b_trans = 1'b0;
         check($sformatf("bwr_done%0d", i), {31'd0, b_done}, 32'd1);
         check($sformatf("bwr_resp%0d", i), {29'd0, b_resp}, {29'd0, RESP_OK});
         b_wdata = 32'(i + 1);
      end
      @(posedge clk);
      #1;
      check("bwr_done_end", {31'd0, b_done}, 32'd0);

      // B: 8-beat read burst
      @(negedge clk);
      b_trans = 1'b1; b_cmd = CMD_READ; b_addr = 34'h100; b_bc = 4'd7;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         b_trans = 1'b0;
         check($sformatf("brd_done%0d", i), {31'd0, b_done}, 32'd1);
         check($sformatf("brd_rdata%0d", i), b_rdata, 32'(i));
      end
      @(posedge clk);
      #1;
      check("brd_done_end", {31'd0, b_done}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
